fetch_stage: RTL and testbench

- IF stage controller: owns the PC register and drives the synchronous instruction memory (1-cycle read latency).
- Produces the IF/ID pipeline register (pc, instr, valid) consumed by the ID stage (imm_gen, register file).
- Supports hazard stalls with an internal skid/hold buffer, and branch redirects with a flush of in-flight fetches.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage controller.
// Owns the PC, drives a synchronous IMEM (one-cycle read latency) and produces
// the IF/ID pipeline register. A one-entry hold buffer captures the word
// returning from IMEM when a stall begins. The word is then replayed when the
// stall releases, so no instruction is lost or duplicated. A redirect loads a
// new PC and squashes everything already in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_MASK   = 32'h0000_007F,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  // Architectural state: fetch PC, outstanding IMEM response tag, hold buffer
  // and the IF/ID register itself.
  logic [31:0] pc_r;
  logic [31:0] resp_pc_r;
  logic        resp_valid_r;
  logic [31:0] hold_r;
  logic        hold_valid_r;
  logic [31:0] if_id_pc_r;
  logic [31:0] if_id_instr_r;
  logic        if_id_valid_r;

  // Next-state values computed combinationally, registered in one place.
  logic [31:0] pc_nxt_s;
  logic [31:0] resp_pc_nxt_s;
  logic        resp_valid_nxt_s;
  logic [31:0] hold_nxt_s;
  logic        hold_valid_nxt_s;
  logic [31:0] if_id_pc_nxt_s;
  logic [31:0] if_id_instr_nxt_s;
  logic        if_id_valid_nxt_s;

  // Word to deliver into IF/ID: the held word has priority over live IMEM data.
  logic [31:0] src_data_s;
  // Sequential successor of the current fetch PC.
  logic [31:0] seq_pc_s;

  // Keep every PC inside the IMEM window. The address wraps at the top.
  function automatic logic [31:0] mask_pc(input logic [31:0] addr);
    return addr & PC_MASK;
  endfunction

  assign src_data_s = hold_valid_r ? hold_r : imem_rdata_i;
  assign seq_pc_s   = mask_pc(pc_r + 32'd4);

  // Next-state selection. A redirect beats a stall, and a stall beats normal advance.
  always_comb begin
    pc_nxt_s          = pc_r;
    resp_pc_nxt_s     = resp_pc_r;
    resp_valid_nxt_s  = resp_valid_r;
    hold_nxt_s        = hold_r;
    hold_valid_nxt_s  = hold_valid_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_valid_nxt_s = if_id_valid_r;

    if (redirect_i) begin
      // Squash the in-flight response and the held word. IF/ID turns into a bubble.
      // The target reaches IF/ID two edges later.
      pc_nxt_s          = mask_pc(redirect_pc_i);
      resp_valid_nxt_s  = 1'b0;
      hold_valid_nxt_s  = 1'b0;
      if_id_valid_nxt_s = 1'b0;
      if_id_instr_nxt_s = NOP_INSTR;
    end else if (stall_i) begin
      // Freeze the pipeline. Capture the returning word only on the first
      // stalled cycle, because later cycles return data for pc_r. That word
      // is fetched again after release.
      if (resp_valid_r && !hold_valid_r) begin
        hold_nxt_s       = imem_rdata_i;
        hold_valid_nxt_s = 1'b1;
      end else begin
        hold_nxt_s       = hold_r;
        hold_valid_nxt_s = hold_valid_r;
      end
    end else begin
      // Advance by one instruction. Move the outstanding response into IF/ID.
      pc_nxt_s          = seq_pc_s;
      resp_pc_nxt_s     = pc_r;
      resp_valid_nxt_s  = 1'b1;
      if_id_pc_nxt_s    = resp_pc_r;
      if_id_valid_nxt_s = resp_valid_r;
      if_id_instr_nxt_s = resp_valid_r ? src_data_s : NOP_INSTR;
      hold_valid_nxt_s  = 1'b0;
    end
  end

  // State register with synchronous, active-high reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      resp_pc_r     <= 32'h0000_0000;
      resp_valid_r  <= 1'b0;
      hold_r        <= 32'h0000_0000;
      hold_valid_r  <= 1'b0;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      resp_pc_r     <= resp_pc_nxt_s;
      resp_valid_r  <= resp_valid_nxt_s;
      hold_r        <= hold_nxt_s;
      hold_valid_r  <= hold_valid_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
    end
  end

  // All outputs come straight from flops.
  assign imem_addr_o   = pc_r;
  assign if_id_pc_o    = if_id_pc_r;
  assign if_id_instr_o = if_id_instr_r;
  assign if_id_valid_o = if_id_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic.
// The reference model tracks the instruction stream abstractly. It holds the
// next PC to deliver and whether the one-cycle fetch pipe has been primed
// since the last reset or redirect.
module tb_fetch_stage;

  localparam logic [31:0] MASK  = 32'h0000_007F;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WBASE = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_next;
  bit          m_primed;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_pc_known;

  always #5 clk = ~clk;

  // Synchronous IMEM model: word(a) = 0xA0000000 | a, one-cycle latency.
  always @(posedge clk) imem_rdata_i <= WBASE | imem_addr_o;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare all outputs.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    reset = r; stall_i = s; redirect_i = d; redirect_pc_i = t;
    @(posedge clk);
    if (r) begin
      m_next = 32'h0; m_primed = 1'b0; m_valid = 1'b0; m_instr = NOP;
      m_pc = 32'h0; m_pc_known = 1'b1;
    end else if (d) begin
      m_next = t & MASK; m_primed = 1'b0; m_valid = 1'b0; m_instr = NOP;
    end else if (!s) begin
      if (m_primed) begin
        m_pc = m_next; m_instr = WBASE | m_next; m_valid = 1'b1; m_pc_known = 1'b1;
        m_next = (m_next + 32'd4) & MASK;
      end else begin
        m_valid = 1'b0; m_instr = NOP; m_pc_known = 1'b0; m_primed = 1'b1;
      end
    end
    #1;
    chk("valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
    chk("instr", if_id_instr_o, m_instr);
    chk("imem_addr", imem_addr_o, (m_next + (m_primed ? 32'd4 : 32'd0)) & MASK);
    if (m_pc_known) chk("pc", if_id_pc_o, m_pc);
  endtask

  // Literal expectation of a delivered instruction at a known PC.
  task automatic expect_ifid(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_id_valid_o}, 32'd1);
    chk({tag, "_pc"}, if_id_pc_o, pc);
    chk({tag, "_instr"}, if_id_instr_o, WBASE | pc);
  endtask

  logic [31:0] frozen_addr;

  initial begin
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    m_next = 32'h0; m_primed = 1'b0; m_valid = 1'b0; m_instr = NOP;
    m_pc = 32'h0; m_pc_known = 1'b1;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("rst_instr", if_id_instr_o, NOP);
    chk("rst_pc", if_id_pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);

    // First valid at the second edge, then one instruction per cycle.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_edge_bubble", {31'd0, if_id_valid_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("start0", 32'h00);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("start4", 32'h04);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("start8", 32'h08);

    // Three-cycle stall holding 0x08, with the IMEM address frozen.
    frozen_addr = imem_addr_o;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      expect_ifid("stall_hold", 32'h08);
      chk("stall_addr", imem_addr_o, frozen_addr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("post_stall_c", 32'h0C);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("post_stall_10", 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("pre_redir_14", 32'h14);

    // Redirect to 0x40.
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("redir_flush_instr", if_id_instr_o, NOP);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_bubble2", {31'd0, if_id_valid_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("redir_tgt", 32'h40);

    // Run to 0x7C and wrap to 0x00.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("top_7c", 32'h7C);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("wrap_00", 32'h00);

    // Out-of-range target is masked.
    step(1'b0, 1'b0, 1'b1, 32'h84);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("mask_04", 32'h04);

    // Simultaneous stall and redirect: the redirect wins.
    step(1'b0, 1'b1, 1'b1, 32'h20);
    chk("stall_redir_valid", {31'd0, if_id_valid_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("stall_redir_20", 32'h20);

    // Stall with nothing in flight right after a redirect.
    step(1'b0, 1'b0, 1'b1, 32'h30);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("empty_stall_30", 32'h30);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("empty_stall_34", 32'h34);

    // Reset in the middle of a two-cycle stall discards the held word.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_stall_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("rst_stall_addr", imem_addr_o, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("restart_00", 32'h00);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_ifid("restart_04", 32'h04);

    // Random traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
